// File: rtl/clockport_bus_ctrl.sv
// Clockport-to-Pi latch sequencer: synchronises clockport strobes/address and
// drives the data latch LE/OE, direction and the Pi request/acknowledge handshake.
module clockport_bus_ctrl #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LE_PULSE    = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cp_cs_n,
  input  logic              cp_iord_n,
  input  logic              cp_iowr_n,
  input  logic [ADDR_W-1:0] cp_addr,
  output logic              latch_le_n,
  output logic              latch_oe_n,
  output logic              dir,
  output logic              pi_req,
  output logic              pi_rnw,
  output logic [ADDR_W-1:0] pi_addr,
  input  logic              pi_ack,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned LE_W  = (LE_PULSE > 1) ? $clog2(LE_PULSE) : 1;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_LATCH, S_WR_WAIT, S_RD_REQ, S_RD_LATCH, S_RD_DRIVE, S_RECOVER
  } state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q, rd_sync_q, wr_sync_q;
  logic [ADDR_W-1:0]      addr_sync_q [SYNC_STAGES];

  state_e            state_q, state_d;
  logic              le_n_q, le_n_d, oe_n_q, oe_n_d, dir_q, dir_d;
  logic              req_q, req_d, rnw_q, rnw_d, busy_q, busy_d, terr_q, terr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LE_W-1:0]   le_cnt_q, le_cnt_d;
  logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;
  logic              cs, rd, wr;

  // Metastability synchronisers on every asynchronous clockport input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_q <= '1;
      rd_sync_q <= '1;
      wr_sync_q <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) addr_sync_q[i] <= '0;
    end else begin
      cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], cp_cs_n};
      rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], cp_iord_n};
      wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], cp_iowr_n};
      addr_sync_q[0] <= cp_addr;
      for (int i = 1; i < SYNC_STAGES; i++) addr_sync_q[i] <= addr_sync_q[i-1];
    end
  end

  assign cs = ~cs_sync_q[SYNC_STAGES-1];
  assign rd = cs & ~rd_sync_q[SYNC_STAGES-1];
  assign wr = cs & ~wr_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      le_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      dir_q    <= 1'b1;
      req_q    <= 1'b0;
      rnw_q    <= 1'b0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
      le_cnt_q <= '0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      le_n_q   <= le_n_d;
      oe_n_q   <= oe_n_d;
      dir_q    <= dir_d;
      req_q    <= req_d;
      rnw_q    <= rnw_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      terr_q   <= terr_d;
      le_cnt_q <= le_cnt_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Next-state and next-output logic; LE/OE default to released every cycle
  always_comb begin
    state_d  = state_q;
    le_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    dir_d    = dir_q;
    req_d    = req_q;
    rnw_d    = rnw_q;
    addr_d   = addr_q;
    terr_d   = 1'b0;
    le_cnt_d = le_cnt_q;
    to_cnt_d = to_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr && !rd) begin
          state_d  = S_WR_LATCH;
          dir_d    = 1'b1;
          addr_d   = addr_sync_q[SYNC_STAGES-1];
          le_n_d   = 1'b0;
          le_cnt_d = '0;
        end else if (rd && !wr) begin
          state_d  = S_RD_REQ;
          dir_d    = 1'b0;
          addr_d   = addr_sync_q[SYNC_STAGES-1];
          rnw_d    = 1'b1;
          req_d    = 1'b1;
          to_cnt_d = '0;
        end else if (rd && wr) begin
          state_d = S_RECOVER;
        end
      end
      S_WR_LATCH, S_RD_LATCH: begin
        if (le_cnt_q == LE_W'(LE_PULSE - 1)) begin
          if (state_q == S_WR_LATCH) begin
            state_d  = S_WR_WAIT;
            req_d    = 1'b1;
            rnw_d    = 1'b0;
            to_cnt_d = '0;
          end else begin
            state_d = S_RD_DRIVE;
          end
        end else begin
          le_n_d   = 1'b0;
          le_cnt_d = le_cnt_q + LE_W'(1);
        end
      end
      S_WR_WAIT, S_RD_REQ: begin
        // Ack is checked before the timeout so a last-cycle ack still completes
        to_cnt_d = to_cnt_q + CNT_W'(1);
        if (pi_ack) begin
          req_d = 1'b0;
          if (state_q == S_WR_WAIT) begin
            state_d = S_RECOVER;
          end else begin
            state_d  = S_RD_LATCH;
            le_n_d   = 1'b0;
            le_cnt_d = '0;
          end
        end else if (to_cnt_d == CNT_W'(TIMEOUT)) begin
          req_d   = 1'b0;
          terr_d  = 1'b1;
          state_d = S_RECOVER;
        end
      end
      S_RD_DRIVE: begin
        if (rd) oe_n_d = 1'b0;
        else    state_d = S_RECOVER;
      end
      S_RECOVER: begin
        if (!cs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign latch_le_n  = le_n_q;
  assign latch_oe_n  = oe_n_q;
  assign dir         = dir_q;
  assign pi_req      = req_q;
  assign pi_rnw      = rnw_q;
  assign pi_addr     = addr_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_clockport_bus_ctrl.sv
// Randomised bench for clockport_bus_ctrl: a transfer-phase model with elapsed-cycle
// timestamps predicts every output each cycle; directed cases pin the model with literals.
module tb_clockport_bus_ctrl;
  localparam int unsigned AW = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned LP = 2;
  localparam int unsigned TO = 255;

  localparam int P_IDLE = 0, P_WLAT = 1, P_WWAIT = 2, P_RREQ = 3, P_RLAT = 4,
                 P_RDRV = 5, P_REC = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cp_cs_n = 1'b1, cp_iord_n = 1'b1, cp_iowr_n = 1'b1;
  logic [AW-1:0] cp_addr = '0;
  logic          pi_ack = 1'b0;
  logic          latch_le_n, latch_oe_n, dir, pi_req, pi_rnw, busy, timeout_err;
  logic [AW-1:0] pi_addr;

  clockport_bus_ctrl #(.ADDR_W(AW), .SYNC_STAGES(SS), .LE_PULSE(LP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cp_cs_n(cp_cs_n), .cp_iord_n(cp_iord_n), .cp_iowr_n(cp_iowr_n),
    .cp_addr(cp_addr), .latch_le_n(latch_le_n), .latch_oe_n(latch_oe_n), .dir(dir),
    .pi_req(pi_req), .pi_rnw(pi_rnw), .pi_addr(pi_addr), .pi_ack(pi_ack), .busy(busy),
    .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [AW+2:0] dl [SS];          // {cs_n, iord_n, iowr_n, addr} as seen SS cycles late
  int            ph, el;
  bit            m_oe_on, m_dir, m_rnw, m_terr;
  logic [AW-1:0] m_addr;

  int le_low, oe_low, req_high, req_rise, terr_cnt, busy_cnt;
  bit req_prev;

  task automatic model_reset();
    for (int i = 0; i < SS; i++) dl[i] = {3'b111, {AW{1'b0}}};
    ph = P_IDLE; el = 0; m_oe_on = 0; m_dir = 1; m_rnw = 0; m_terr = 0; m_addr = '0;
    req_prev = 0;
  endtask

  task automatic model_step();
    logic [AW+2:0] o;
    bit cs, rd, wr;
    int nph;
    o  = dl[SS-1];
    cs = !o[AW+2];
    rd = cs && !o[AW+1];
    wr = cs && !o[AW];
    for (int i = SS - 1; i > 0; i--) dl[i] = dl[i-1];
    dl[0] = {cp_cs_n, cp_iord_n, cp_iowr_n, cp_addr};
    m_terr = 0;
    nph = ph;
    case (ph)
      P_IDLE:
        if (wr && !rd)      begin nph = P_WLAT; m_dir = 1; m_addr = o[AW-1:0]; end
        else if (rd && !wr) begin nph = P_RREQ; m_dir = 0; m_addr = o[AW-1:0]; m_rnw = 1; end
        else if (rd && wr)  nph = P_REC;
      P_WLAT:  if (el == LP - 1) begin nph = P_WWAIT; m_rnw = 0; end
      P_RLAT:  if (el == LP - 1) begin nph = P_RDRV; m_oe_on = 0; end
      P_WWAIT, P_RREQ:
        if (pi_ack)            nph = (ph == P_WWAIT) ? P_REC : P_RLAT;
        else if (el == TO - 1) begin nph = P_REC; m_terr = 1; end
      P_RDRV:  if (rd) m_oe_on = 1; else begin nph = P_REC; m_oe_on = 0; end
      P_REC:   if (!cs) nph = P_IDLE;
      default: nph = P_IDLE;
    endcase
    el = (nph != ph) ? 0 : el + 1;
    ph = nph;
  endtask

  // Compare every cycle on the falling edge, then advance the model to the next rising edge
  always @(negedge clk) begin
    logic [AW+6:0] exp_v, act_v;
    bit e_req;
    if (rst) begin
      model_reset();
    end else begin
      e_req = (ph == P_WWAIT) || (ph == P_RREQ);
      exp_v = {!(ph == P_WLAT || ph == P_RLAT), !(ph == P_RDRV && m_oe_on), m_dir, e_req,
               e_req ? m_rnw : 1'b0, ph != P_IDLE, m_terr, m_addr};
      act_v = {latch_le_n, latch_oe_n, dir, pi_req, e_req ? pi_rnw : 1'b0, busy,
               timeout_err, pi_addr};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_outputs {le_n,oe_n,dir,req,rnw,busy,terr,addr}: got %b expected %b at %0t",
                 act_v, exp_v, $time);
      end
      if (!latch_le_n) le_low++;
      if (!latch_oe_n) oe_low++;
      if (pi_req) req_high++;
      if (pi_req && !req_prev) req_rise++;
      req_prev = pi_req;
      if (timeout_err) terr_cnt++;
      if (busy) busy_cnt++;
      model_step();
    end
  end

  // ---------------- Pi-side acknowledge responder ----------------
  int ack_delay = 0;
  int ack_cnt = 0;
  bit ack_noise = 0;

  always @(posedge clk) begin
    #2;
    if (pi_req) begin
      pi_ack = (ack_cnt == ack_delay);
      ack_cnt++;
    end else begin
      ack_cnt = 0;
      pi_ack = ack_noise ? ($urandom_range(3) == 0) : 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr_mon();
    le_low = 0; oe_low = 0; req_high = 0; req_rise = 0; terr_cnt = 0; busy_cnt = 0;
  endtask

  // kind: 0 = write, 1 = read, 2 = both strobes
  task automatic strobe(input int kind, input logic [AW-1:0] a, input int hold);
    cp_addr   = a;
    cp_cs_n   = 1'b0;
    cp_iord_n = !(kind == 1 || kind == 2);
    cp_iowr_n = !(kind == 0 || kind == 2);
    cyc(hold);
    cp_cs_n = 1'b1; cp_iord_n = 1'b1; cp_iowr_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    cyc(SS + 2);
    while (busy && n < 1000) begin cyc(1); n++; end
    chk("wait_idle_busy", int'(busy), 0);
  endtask

  initial begin
    int n, kind, hold, r;
    clr_mon();
    model_reset();
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("reset_le_n", int'(latch_le_n), 1);
    chk("reset_oe_n", int'(latch_oe_n), 1);
    chk("reset_dir", int'(dir), 1);
    chk("reset_req", int'(pi_req), 0);
    chk("reset_addr", int'(pi_addr), 0);
    chk("reset_busy", int'(busy), 0);

    // Write to 0x5, ack on the 4th request cycle
    clr_mon(); ack_delay = 3;
    strobe(0, 4'h5, 10);
    wait_idle();
    chk("wr_le_low_cycles", le_low, 2);
    chk("wr_req_pulses", req_rise, 1);
    chk("wr_req_high_cycles", req_high, 4);
    chk("wr_oe_low_cycles", oe_low, 0);
    chk("wr_addr", int'(pi_addr), 5);

    // Read from 0xA, strobe held 20 cycles
    clr_mon(); ack_delay = 4;
    strobe(1, 4'hA, 20);
    wait_idle();
    chk("rd_le_low_cycles", le_low, 2);
    chk("rd_oe_low_cycles", oe_low, 12);
    chk("rd_dir", int'(dir), 0);
    chk("rd_addr", int'(pi_addr), 10);

    // Write with no ack: full timeout
    clr_mon(); ack_delay = -1;
    strobe(0, 4'h9, 5);
    wait_idle();
    chk("to_req_high_cycles", req_high, 255);
    chk("to_err_pulses", terr_cnt, 1);
    chk("to_le_low_cycles", le_low, 2);

    // Read with no ack: no output enable afterwards
    clr_mon();
    strobe(1, 4'h3, 30);
    wait_idle();
    chk("rdto_err_pulses", terr_cnt, 1);
    chk("rdto_oe_low_cycles", oe_low, 0);
    chk("rdto_le_low_cycles", le_low, 0);

    // Both strobes: protocol error, no handshake or latch activity
    clr_mon(); ack_delay = 0;
    strobe(2, 4'h7, 15);
    wait_idle();
    chk("err_req_pulses", req_rise, 0);
    chk("err_le_low_cycles", le_low, 0);
    chk("err_oe_low_cycles", oe_low, 0);
    chk("err_busy_seen", int'(busy_cnt > 0), 1);

    // Back-to-back writes with cs held: one transfer until cs toggles
    clr_mon(); ack_delay = 2;
    cp_addr = 4'h3; cp_cs_n = 1'b0; cp_iowr_n = 1'b0;
    cyc(10);
    cp_iowr_n = 1'b1;
    cyc(3);
    cp_iowr_n = 1'b0;
    cyc(30);
    chk("b2b_busy_held", int'(busy), 1);
    chk("b2b_req_pulses_held", req_rise, 1);
    cp_cs_n = 1'b1; cp_iowr_n = 1'b1;
    wait_idle();
    strobe(0, 4'h4, 5);
    wait_idle();
    chk("b2b_req_pulses_after_toggle", req_rise, 2);

    // Reset asserted while driving read data
    clr_mon(); ack_delay = 2;
    cp_addr = 4'hC; cp_cs_n = 1'b0; cp_iord_n = 1'b0;
    n = 0;
    while (latch_oe_n && n < 60) begin cyc(1); n++; end
    chk("rstdrv_oe_reached", int'(latch_oe_n), 0);
    #1 rst = 1'b1;
    #1;
    chk("rstdrv_oe_n_async", int'(latch_oe_n), 1);
    chk("rstdrv_req_async", int'(pi_req), 0);
    chk("rstdrv_busy_async", int'(busy), 0);
    cp_cs_n = 1'b1; cp_iord_n = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);

    // Randomised traffic with spurious acks outside the handshake
    ack_noise = 1;
    for (int it = 0; it < 120; it++) begin
      r    = $urandom_range(9);
      kind = (r < 5) ? 0 : (r < 9) ? 1 : 2;
      ack_delay = ($urandom_range(9) == 0) ? -1 : int'($urandom_range(8));
      hold = $urandom_range(40, 1);
      strobe(kind, 4'($urandom_range(15)), hold);
      wait_idle();
      cyc($urandom_range(3));
    end
    ack_noise = 0;
    cyc(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clockport_bus_ctrl.md
Name: clockport_bus_ctrl

Overview:
Clocked sequencer that sits directly upstream of the 8-bit data latch on the clockport–Pi bridge. It synchronises the Amiga clockport strobes and address, then generates the latch's active-low LE/OE controls and the direction select. It runs a request/acknowledge handshake with the Pi side so that each write byte is latched toward the Pi and each read byte is latched and driven toward the Amiga.

Parameters:
ADDR_W, 4, width of clockport register address
SYNC_STAGES, 2, flip-flop stages on each asynchronous clockport input (min 2)
LE_PULSE, 2, clk cycles latch_le_n is held low (transparent) per transfer (min 1)
TIMEOUT, 255, clk cycles to wait for pi_ack before abort (8-bit counter)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
cp_cs_n  in  1  clockport chip select, active-low, asynchronous
cp_iord_n  in  1  clockport read strobe, active-low, asynchronous
cp_iowr_n  in  1  clockport write strobe, active-low, asynchronous
cp_addr  in  ADDR_W  clockport address, asynchronous
latch_le_n  out  1  latch enable to data latch, active-low (low = transparent)
latch_oe_n  out  1  latch output enable, active-low
dir  out  1  1 = Amiga->Pi (write), 0 = Pi->Amiga (read)
pi_req  out  1  transfer request to Pi
pi_rnw  out  1  1 = read, 0 = write; valid while pi_req=1
pi_addr  out  ADDR_W  captured address; valid while pi_req=1
pi_ack  in  1  Pi acknowledge, synchronous to clk
busy  out  1  high in any state other than IDLE
timeout_err  out  1  one-cycle pulse on handshake timeout

Behaviour:
- Reset (async, immediate): state=IDLE, latch_le_n=1, latch_oe_n=1, dir=1, pi_req=0, pi_rnw=0, pi_addr=0, busy=0, timeout_err=0, counters=0. Asserting reset mid-transfer drops all outputs to these values in the same instant.
- All cp_* inputs pass through SYNC_STAGES flops. All decisions use the synced values. cs=~cp_cs_n_s, rd=cs&~cp_iord_n_s, wr=cs&~cp_iowr_n_s.
- IDLE:
  - wr&~rd -> WR_LATCH: dir=1, capture pi_addr, le_cnt=0.
  - rd&~wr -> RD_REQ: dir=0, capture pi_addr, pi_rnw=1, pi_req=1.
  - rd&wr (protocol error) -> RECOVER, no outputs changed.
  - dir changes only on the IDLE exit edge.
- WR_LATCH: latch_le_n=0 for exactly LE_PULSE cycles, then 1 -> WR_WAIT: pi_req=1, pi_rnw=0.
- WR_WAIT: on pi_ack -> pi_req=0 next edge -> RECOVER.
- RD_REQ: on pi_ack -> pi_req=0 -> RD_LATCH. Pi data is valid on the latch inputs when it asserts pi_ack.
- RD_LATCH: latch_le_n=0 for LE_PULSE cycles -> RD_DRIVE.
- RD_DRIVE: latch_oe_n=0 while rd remains; when rd deasserts -> latch_oe_n=1 -> RECOVER.
- RECOVER: wait until cs=0 (synced), then -> IDLE. A new transfer requires cs to deassert first, so one strobe gives exactly one transfer.
- Timeout: in WR_WAIT and RD_REQ the counter increments each cycle and clears on state entry. At count==TIMEOUT with no ack: pi_req=0, timeout_err=1 for one cycle, -> RECOVER. latch_oe_n is never asserted after a read timeout.
- pi_ack in the same cycle the counter reaches TIMEOUT: ack wins, no error.
- pi_ack outside WR_WAIT/RD_REQ is ignored.
- Strobe deasserting early:
  - In WR_LATCH or WR_WAIT: the transfer completes normally, because data was already captured.
  - In RD_REQ or RD_LATCH: the sequence completes, then RD_DRIVE sees rd=0 and exits immediately, so latch_oe_n stays high.
- Latency: strobe edge to state change = SYNC_STAGES+1 clk. latch_le_n and latch_oe_n are registered outputs, glitch-free.

Test Plan:
- Write, addr=0x5, ack 3 cycles after req -> latch_le_n low 2 cycles; then pi_req=1, pi_rnw=0, pi_addr=0x5; req drops the cycle after ack; latch_oe_n stays 1; busy falls 1 cycle after cs deasserts (synced).
- Read, addr=0xA, ack after 4 cycles, strobe held 20 cycles -> dir=0, pi_rnw=1; after ack, latch_le_n low 2 cycles; latch_oe_n low until synced iord high; then 1.
- Write with no ack -> pi_req high 255 cycles; timeout_err pulses exactly once; FSM reaches IDLE after cs releases.
- Both cp_iord_n and cp_iowr_n low with cs -> no pi_req, no LE/OE activity, busy until cs released.
- rst asserted during RD_DRIVE -> latch_oe_n=1 and pi_req=0 asynchronously before the next clk edge.
- Two back-to-back writes, cs held low across both -> only one transfer; the second transfer occurs only after cs toggles high then low.
